// File: rtl/maxpool_arb_if.sv
// Handshake bundle between the requesters, the shared maxpool engine and the
// pooled-row consumer. The slave modport is the arbiter's view; the master
// modport is the surrounding environment's view.
interface maxpool_arb_if #(
  parameter int unsigned N = 4,
  parameter int unsigned R = 10,
  parameter int unsigned W = 8
);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  // requester rows
  logic [N-1:0]         s_valid;
  logic [N-1:0]         s_ready;
  logic [N*R*W-1:0]     s_data;
  // row to engine
  logic                 e_valid;
  logic                 e_ready;
  logic [R*W-1:0]       e_data;
  // pooled row from engine
  logic                 r_valid;
  logic                 r_ready;
  logic [(R/2)*W-1:0]   r_data;
  // pooled row out, tagged with its owner
  logic                 m_valid;
  logic                 m_ready;
  logic [(R/2)*W-1:0]   m_data;
  logic [IW-1:0]        m_id;
  logic                 err;

  modport slave (
    input  s_valid, s_data, e_ready, r_valid, r_data, m_ready,
    output s_ready, e_valid, e_data, r_ready, m_valid, m_data, m_id, err
  );

  modport master (
    output s_valid, s_data, e_ready, r_valid, r_data, m_ready,
    input  s_ready, e_valid, e_data, r_ready, m_valid, m_data, m_id, err
  );
endinterface

// File: rtl/maxpool_arb.sv
// Shares one maxpool engine between N requesters. A grant covers a pair of
// rows; the owner's id is queued in a small tag FIFO and re-attached to the
// pooled result on its way out. Tag FIFO depth D must be a power of two >= 2.
// Optional feature: define MAXPOOL_ARB_PRIO0_EN to give requester 0 absolute
// precedence in every arbitration cycle.
module maxpool_arb #(
  parameter int unsigned N = 4,
  parameter int unsigned R = 10,
  parameter int unsigned W = 8,
  parameter int unsigned D = 2
) (
  input  logic         clk,
  input  logic         rstn,
  maxpool_arb_if.slave bus
);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned AW = (D > 1) ? $clog2(D) : 1;
  localparam int unsigned CW = $clog2(D + 1);
  localparam int unsigned RW = R * W;

  typedef enum logic [1:0] {ARB, ROW0, ROW1} state_t;

  state_t        r_state;
  logic [IW-1:0] r_grant;
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] r_fifo [D];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  logic          r_err;

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [IW-1:0]  w_sel;
  logic [IW-1:0]  w_next;
  logic           w_full;
  logic           w_empty;
  logic           w_push;
  logic           w_pop;
  logic           w_hs;
  logic           w_sv;
  logic [N-1:0]   w_s_ready;
  logic [RW-1:0]  w_edata;

  // (a + k) mod N without a divider; k < N
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input int unsigned k);
    logic [IW:0] s;
    s = {1'b0, a} + (IW+1)'(k);
    if (s >= (IW+1)'(N)) s = s - (IW+1)'(N);
    return s[IW-1:0];
  endfunction

  assign w_full  = (r_cnt == CW'(D));
  assign w_empty = (r_cnt == '0);
  assign w_push  = (r_state == ARB) && (|bus.s_valid) && !w_full;
  assign w_pop   = bus.m_valid && bus.m_ready;
  assign w_hs    = bus.e_valid && bus.e_ready;
  assign w_next  = (r_grant == IW'(N - 1)) ? '0 : r_grant + IW'(1);

  // Rotate the valids so bit k means requester (p + k) mod N
  assign w_dbl = {bus.s_valid, bus.s_valid};
  assign w_rot = N'(w_dbl >> r_ptr);

  // Round-robin pick: first valid requester at or after the pointer
  always_comb begin
    w_sel = r_ptr;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) w_sel = wrap_add(r_ptr, k);
    end
`ifdef MAXPOOL_ARB_PRIO0_EN
    if (bus.s_valid[0]) w_sel = '0;
`endif
  end

  // Route the granted requester to the engine while a pair is in progress
  always_comb begin
    w_s_ready = '0;
    w_edata   = '0;
    w_sv      = 1'b0;
    for (int i = 0; i < N; i++) begin
      if ((r_state != ARB) && (r_grant == IW'(i))) begin
        w_s_ready[i] = bus.e_ready;
        w_edata      = bus.s_data[i*RW +: RW];
        w_sv         = bus.s_valid[i];
      end
    end
  end

  assign bus.s_ready = w_s_ready;
  assign bus.e_valid = w_sv;
  assign bus.e_data  = w_edata;

  // Result path is purely combinational; tag head names the owner
  assign bus.m_valid = bus.r_valid && !w_empty;
  assign bus.m_data  = bus.r_data;
  assign bus.m_id    = w_empty ? '0 : r_fifo[r_rd];
  assign bus.r_ready = bus.m_ready && !w_empty;
  assign bus.err     = r_err;

  // Pair FSM, round-robin pointer, tag FIFO pointers and sticky orphan flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ARB;
      r_grant <= '0;
      r_ptr   <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ARB: begin
          if (w_push) begin
            r_grant <= w_sel;
            r_state <= ROW0;
          end
        end
        ROW0: begin
          if (w_hs) r_state <= ROW1;
        end
        ROW1: begin
          if (w_hs) begin
            r_state <= ARB;
            r_ptr   <= w_next;
          end
        end
        default: r_state <= ARB;
      endcase

      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);

      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase

      if (bus.r_valid && w_empty) r_err <= 1'b1;
    end
  end

  // Tag storage; contents are only observed while the FIFO is non-empty
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr] <= w_sel;
  end
endmodule

// File: tb/tb_maxpool_arb.sv
// Directed bench for maxpool_arb with default parameters (N=4, R=10, W=8, D=2).
module tb_maxpool_arb;
  localparam int unsigned N  = 4;
  localparam int unsigned R  = 10;
  localparam int unsigned W  = 8;
  localparam int unsigned D  = 2;
  localparam int unsigned RW = R * W;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  maxpool_arb_if #(.N(N), .R(R), .W(W)) bus ();

  maxpool_arb #(.N(N), .R(R), .W(W), .D(D)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.s_valid = '0;
    bus.s_data  = '0;
    bus.e_ready = 1'b0;
    bus.r_valid = 1'b0;
    bus.r_data  = '0;
    bus.m_ready = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    idle_inputs();
    repeat (2) tick();
    rstn = 1'b1;
  endtask

  function automatic int oh2id(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  int beat_id[$];
  int beat_cyc[$];
  int mid_q[$];
  int pend;
  int exp_beat[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
  logic [RW-1:0] row_a;
  logic [RW-1:0] row_b;
  logic [RW-1:0] row_d;

  initial begin
    row_a = 80'h0102030405060708090A;
    row_b = 80'hA1A2A3A4A5A6A7A8A9AA;
    row_d = 80'h112233445566778899AA;

    // Reset state, asserted with requesters already valid
    rstn = 1'b0;
    idle_inputs();
    bus.s_valid = 4'b1111;
    bus.e_ready = 1'b1;
    bus.m_ready = 1'b1;
    #2;
    chk("rst_s_ready", bus.s_ready, 4'b0000);
    chk("rst_e_valid", bus.e_valid, 1'b0);
    chk("rst_m_valid", bus.m_valid, 1'b0);
    chk("rst_r_ready", bus.r_ready, 1'b0);
    chk("rst_m_id",    bus.m_id,    2'd0);
    chk("rst_err",     bus.err,     1'b0);

    // Round robin with all valid and a responsive engine model
    do_reset();
    bus.s_valid = 4'b1111;
    bus.e_ready = 1'b1;
    bus.m_ready = 1'b1;
    bus.r_data  = 40'h0A0B0C0D0E;
    pend = 0;
    #1;
    chk("arb_after_rst_s_ready", bus.s_ready, 4'b0000);
    chk("arb_after_rst_e_valid", bus.e_valid, 1'b0);
    for (int c = 0; c < 40; c++) begin
      bus.r_valid = (pend > 0);
      #1;
      if (bus.r_valid && bus.r_ready) begin
        mid_q.push_back(int'(bus.m_id));
        pend--;
      end
      if (bus.e_valid && bus.e_ready) begin
        beat_id.push_back(oh2id(bus.s_ready));
        beat_cyc.push_back(c);
        if ((beat_id.size() % 2) == 0) pend++;
      end
      tick();
    end
    bus.r_valid = 1'b0;
    chk("rr_beat_count_ge10", 128'(beat_id.size() >= 10), 128'(1));
    if (beat_id.size() >= 10) begin
      for (int i = 0; i < 10; i++) chk($sformatf("rr_beat%0d", i), 128'(beat_id[i]), 128'(exp_beat[i]));
      chk("rr_pair_consecutive", 128'(beat_cyc[1] - beat_cyc[0]), 128'(1));
      chk("rr_arb_gap",          128'(beat_cyc[2] - beat_cyc[1]), 128'(2));
    end
    chk("rr_mid_count_ge4", 128'(mid_q.size() >= 4), 128'(1));
    if (mid_q.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk($sformatf("rr_mid%0d", i), 128'(mid_q[i]), 128'(i));
    end
    chk("rr_err", bus.err, 1'b0);

    // Tag FIFO full blocks the third grant until a result drains
    do_reset();
    bus.s_valid = 4'b1111;
    bus.e_ready = 1'b1;
    repeat (6) tick();
    #1;
    chk("full_c6_e_valid", bus.e_valid, 1'b0);
    chk("full_c6_s_ready", bus.s_ready, 4'b0000);
    tick();
    tick();
    bus.r_valid = 1'b1;
    bus.m_ready = 1'b1;
    bus.r_data  = 40'h1234567890;
    #1;
    chk("full_c8_e_valid", bus.e_valid, 1'b0);
    chk("full_pop_m_valid", bus.m_valid, 1'b1);
    chk("full_pop_m_id",    bus.m_id,    2'd0);
    chk("full_pop_r_ready", bus.r_ready, 1'b1);
    tick();
    bus.r_valid = 1'b0;
    #1;
    chk("full_arb_e_valid", bus.e_valid, 1'b0);
    chk("full_arb_s_ready", bus.s_ready, 4'b0000);
    chk("full_head_m_id",   bus.m_id,    2'd1);
    tick();
    #1;
    chk("full_resume_s_ready", bus.s_ready, 4'b0100);
    chk("full_resume_e_valid", bus.e_valid, 1'b1);

    // Requester 2 stalls mid-pair; grant stays locked
    do_reset();
    bus.s_valid = 4'b0100;
    bus.s_data[2*RW +: RW] = row_a;
    bus.e_ready = 1'b1;
    tick();
    #1;
    chk("stall_rowa_e_valid", bus.e_valid, 1'b1);
    chk("stall_rowa_e_data",  bus.e_data,  row_a);
    chk("stall_rowa_s_ready", bus.s_ready, 4'b0100);
    tick();
    bus.s_valid = 4'b1010;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("stall_gap%0d_e_valid", k), bus.e_valid, 1'b0);
      chk($sformatf("stall_gap%0d_s_ready", k), bus.s_ready, 4'b0100);
      tick();
    end
    bus.s_valid = 4'b1110;
    bus.s_data[2*RW +: RW] = row_b;
    #1;
    chk("stall_rowb_e_valid", bus.e_valid, 1'b1);
    chk("stall_rowb_e_data",  bus.e_data,  row_b);
    chk("stall_rowb_s_ready", bus.s_ready, 4'b0100);
    tick();
    #1;
    chk("stall_arb_s_ready", bus.s_ready, 4'b0000);
    tick();
    #1;
    chk("stall_next_s_ready", bus.s_ready, 4'b1000);

    // Extreme pixel values for requester 3 pass through untouched
    do_reset();
    bus.s_valid = 4'b1000;
    bus.s_data[3*RW +: RW] = row_d;
    bus.e_ready = 1'b1;
    tick();
    #1;
    chk("px_e_data", bus.e_data, row_d);
    tick();
    tick();
    bus.s_valid = 4'b0000;
    bus.r_valid = 1'b1;
    bus.r_data  = 40'h5A807FFF00;
    bus.m_ready = 1'b1;
    #1;
    chk("px_m_valid", bus.m_valid, 1'b1);
    chk("px_m_id",    bus.m_id,    2'd3);
    chk("px_m_data",  bus.m_data,  40'h5A807FFF00);
    chk("px_r_ready", bus.r_ready, 1'b1);
    tick();
    bus.r_valid = 1'b0;
    #1;
    chk("px_drained_m_id", bus.m_id, 2'd0);
    chk("px_err",          bus.err,  1'b0);

    // Orphan result sets the sticky error flag
    do_reset();
    bus.r_valid = 1'b1;
    bus.m_ready = 1'b1;
    #1;
    chk("orph_r_ready", bus.r_ready, 1'b0);
    chk("orph_m_valid", bus.m_valid, 1'b0);
    chk("orph_err_same_cycle", bus.err, 1'b0);
    tick();
    bus.r_valid = 1'b0;
    #1;
    chk("orph_err_set", bus.err, 1'b1);
    repeat (3) tick();
    chk("orph_err_held", bus.err, 1'b1);
    rstn = 1'b0;
    #1;
    chk("orph_err_cleared", bus.err, 1'b0);
    tick();
    rstn = 1'b1;

    // Asynchronous reset during ROW1 drops the pair and its tag
    do_reset();
    bus.s_valid = 4'b0010;
    bus.e_ready = 1'b1;
    bus.m_ready = 1'b1;
    tick();
    tick();
    #1;
    chk("arst_pre_s_ready", bus.s_ready, 4'b0010);
    chk("arst_pre_m_id",    bus.m_id,    2'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_s_ready", bus.s_ready, 4'b0000);
    chk("arst_e_valid", bus.e_valid, 1'b0);
    chk("arst_m_valid", bus.m_valid, 1'b0);
    chk("arst_r_ready", bus.r_ready, 1'b0);
    chk("arst_m_id",    bus.m_id,    2'd0);
    chk("arst_err",     bus.err,     1'b0);
    tick();
    rstn = 1'b1;
    bus.s_valid = 4'b1111;
    tick();
    #1;
    chk("arst_restart_s_ready", bus.s_ready, 4'b0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
